// File: rtl/cla_pkg.sv
// cla_pkg: shared group width, group P/G pair type and stage-count helper for the pipelined CLA
package cla_pkg;
   localparam int CLA_GRP_W = 4;
   typedef struct packed {
      logic p;
      logic g;
   } cla_pg_t;
   function automatic int cla_stages(input int width, input int gps);
      return width / (CLA_GRP_W * gps);
   endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group producing sum, group P/G and carry out
module cla_group4
   import cla_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output cla_pg_t    pg,
   output logic       co
);
   logic [3:0] p, g, c;
   assign p = a ^ b;
   assign g = a & b;
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign pg.p = &p;
   assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign co = pg.g | (pg.p & ci);
   assign s = p ^ c;
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: valid/ready pipelined CLA add/sub, GPS 4-bit groups resolved per stage.
// Define PIPELINED_CLA_OVF_EN to build the registered signed-overflow output.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GPS   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SW     = CLA_GRP_W * GPS;
   localparam int STAGES = cla_stages(WIDTH, GPS);
   if (WIDTH % SW != 0 || WIDTH < SW) begin : g_bad
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4*GPS");
   end
   logic [STAGES-1:0] v, ld;
   logic [STAGES:0]   vs;
   logic [WIDTH-1:0]  bx;
   assign bx        = b ^ {WIDTH{sub}};
   assign vs        = {v, in_valid};
   assign in_ready  = ld[0];
   assign out_valid = v[STAGES-1];
   // a stage loads when empty or when its content moves on this edge
   always_comb begin
      ld[STAGES-1] = !v[STAGES-1] || out_ready;
      for (int i = STAGES - 2; i >= 0; i--) ld[i] = !v[i] || ld[i + 1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) v <= '0;
      else for (int i = 0; i < STAGES; i++) if (ld[i]) v[i] <= vs[i];
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int R = (k + 1) * SW;
      localparam int U = WIDTH - R;
      logic [SW-1:0]  ga, gb, gs;
      logic [GPS-1:0] unused_co;
      logic [R-1:0]   s, s_d;
      logic           c, ci0;
      if (k == 0) begin : g_src
         assign ga  = a[SW-1:0];
         assign gb  = bx[SW-1:0];
         assign ci0 = sub | cin;
         assign s_d = gs;
      end else begin : g_src
         assign ga  = g_st[k-1].g_u.ua[SW-1:0];
         assign gb  = g_st[k-1].g_u.ub[SW-1:0];
         assign ci0 = g_st[k-1].c;
         assign s_d = {gs, g_st[k-1].s};
      end
      for (genvar j = 0; j < GPS; j++) begin : g_grp
         cla_pg_t pg;
         logic    ci, cn;
         if (j == 0) begin : g_ci
            assign ci = ci0;
         end else begin : g_ci
            assign ci = g_grp[j-1].cn;
         end
         cla_group4 u_grp (
            .a (ga[j*CLA_GRP_W +: CLA_GRP_W]),
            .b (gb[j*CLA_GRP_W +: CLA_GRP_W]),
            .ci(ci),
            .s (gs[j*CLA_GRP_W +: CLA_GRP_W]),
            .pg(pg),
            .co(unused_co[j])
         );
         assign cn = pg.g | (pg.p & ci);
      end
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            s <= '0;
            c <= 1'b0;
         end else if (ld[k]) begin
            s <= s_d;
            c <= g_grp[GPS-1].cn;
         end
      if (U > 0) begin : g_u
         logic [U-1:0] ua, ub, ua_d, ub_d;
         if (k == 0) begin : g_d
            assign ua_d = a[WIDTH-1:SW];
            assign ub_d = bx[WIDTH-1:SW];
         end else begin : g_d
            assign ua_d = g_st[k-1].g_u.ua[U+SW-1:SW];
            assign ub_d = g_st[k-1].g_u.ub[U+SW-1:SW];
         end
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               ua <= '0;
               ub <= '0;
            end else if (ld[k]) begin
               ua <= ua_d;
               ub <= ub_d;
            end
      end
`ifdef PIPELINED_CLA_OVF_EN
      // carry into the MSB is recovered from its sum bit and operand bits
      if (k == STAGES - 1) begin : g_ovf
         logic o;
         always_ff @(posedge clk or posedge rst)
            if (rst) o <= 1'b0;
            else if (ld[k]) o <= gs[SW-1] ^ ga[SW-1] ^ gb[SW-1] ^ g_grp[GPS-1].cn;
      end
`endif
   end
   assign sum  = g_st[STAGES-1].s;
   assign cout = g_st[STAGES-1].c;
`ifdef PIPELINED_CLA_OVF_EN
   assign ovf = g_st[STAGES-1].g_ovf.o;
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: vector table, directed handshake/reset sequences and randomized scoreboard
// for pipelined_cla_adder at 16/1 and 32/2; honours PIPELINED_CLA_OVF_EN for ovf expectations.
module tb_pipelined_cla_adder;
   localparam int W   = 16;
   localparam int W2  = 32;
   localparam int LAT = 4;
`ifdef PIPELINED_CLA_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 0, cout, ovf;
   logic [W-1:0] a = '0, b = '0, sum;
   logic in_valid2 = 0, in_ready2, cin2 = 0, sub2 = 0, out_valid2, out_ready2 = 1, cout2, ovf2;
   logic [W2-1:0] a2 = '0, b2 = '0, sum2;
   int checks = 0;
   int errors = 0;
   int pops = 0;

   pipelined_cla_adder #(.WIDTH(W), .GPS(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );
   pipelined_cla_adder #(.WIDTH(W2), .GPS(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
      .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // arithmetic reference: {ovf, cout, sum} from plain integer addition on w bits
   function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic s);
      logic [63:0] mask, xx, yy, r;
      logic [64:0] full;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      xx   = x & mask;
      yy   = s ? (~y & mask) : (y & mask);
      full = {1'b0, xx} + {1'b0, yy} + {64'd0, (s | ci)};
      r    = full[63:0] & mask;
      co   = full[w];
      ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
      return {ov & OVF_ON, co, r};
   endfunction

   // scoreboard on the 16-bit instance: every accepted beat predicted, every emitted beat checked
   logic [65:0]  q[$];
   logic         hold_v = 1'b0;
   logic [W-1:0] hold_s = '0;
   always @(negedge clk) begin
      logic [65:0] e;
      if (rst) begin
         q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) check("stall_stable", {out_valid, sum}, {1'b1, hold_s});
         hold_v = out_valid && !out_ready;
         hold_s = sum;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got sum %0h, expected no beat", sum);
            end else begin
               e = q.pop_front();
               check("sb_sum", {48'd0, sum}, e[63:0]);
               check("sb_cout", {63'd0, cout}, {63'd0, e[64]});
               check("sb_ovf", {63'd0, ovf}, {63'd0, e[65]});
               pops++;
            end
         end
         if (in_valid && in_ready) q.push_back(model(W, {48'd0, a}, {48'd0, b}, cin, sub));
      end
   end

   task automatic run_vec(input string name, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vsb, input logic [15:0] es,
                          input logic ec, input logic eo);
      int n;
      a = va; b = vb; cin = vc; sub = vsb; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_lat"}, n, LAT);
      check({name, "_sum"}, {48'd0, sum}, {48'd0, es});
      check({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
      check({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo & OVF_ON});
      @(posedge clk); #1;
   endtask

   task automatic run_vec2(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic vc, input logic vsb, input logic [31:0] es,
                           input logic ec, input logic eo);
      int n;
      a2 = va; b2 = vb; cin2 = vc; sub2 = vsb; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 1;
      while (!out_valid2 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_lat"}, n, LAT);
      check({name, "_sum"}, {32'd0, sum2}, {32'd0, es});
      check({name, "_cout"}, {63'd0, cout2}, {63'd0, ec});
      check({name, "_ovf"}, {63'd0, ovf2}, {63'd0, eo});
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] s;
      logic        c, o;
   } vec_t;
   vec_t vt[9];

   initial begin
      int p0, n_acc, n;
      logic fire;
      logic [65:0] e;
      vt = '{
         '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
         '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
         '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
         '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0},
         '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0},
         '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1},
         '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
         '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}
      };
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum", {48'd0, sum}, 64'd0);
      check("rst_cout", {63'd0, cout}, 64'd0);
      check("rst_ovf", {63'd0, ovf}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid2", {63'd0, out_valid2}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      foreach (vt[i])
         run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].s, vt[i].c, vt[i].o);

      run_vec2("w32_spec", 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000001, 1'b0, OVF_ON);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra, rb;
         logic rc, rs;
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         e = model(W2, {32'd0, ra}, {32'd0, rb}, rc, rs);
         run_vec2($sformatf("w32_rnd%0d", i), ra, rb, rc, rs, e[31:0], e[64], e[65]);
      end

      // back-to-back stream: one result per cycle once the pipe is full
      p0 = pops;
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("stream_mid", pops - p0, 32 - LAT);
      repeat (LAT) @(posedge clk);
      #1;
      check("stream_all", pops - p0, 32);
      check("stream_empty", {63'd0, out_valid}, 64'd0);

      // backpressure: pipe fills to 4 beats then in_ready drops
      p0 = pops;
      n_acc = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) begin
            n_acc++;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
      end
      check("bp_accepted", n_acc, 4);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_head_sum", {48'd0, sum}, (q.size() > 0) ? q[0][63:0] : 64'hDEAD);
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_drained", pops - p0, 4);

      // reset with 3 beats in flight, the oldest already presented
      out_ready = 1'b0;
      a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h2222; b = 16'h0101;
      @(posedge clk); #1;
      a = 16'h4000; b = 16'h0003;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("prerst_valid", {63'd0, out_valid}, 64'd1);
      check("prerst_sum", {48'd0, sum}, 64'h2345);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_sum", {48'd0, sum}, 64'd0);
      check("midrst_cout", {63'd0, cout}, 64'd0);
      check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) n++;
      end
      check("postrst_no_stale", n, 0);
      run_vec("postrst", 16'h0102, 16'h0304, 1'b1, 1'b0, 16'h0407, 1'b0, 1'b0);

      // randomized valid/ready traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         if (i % 50 == 0) begin
            a = 16'hFFFF;
            b = (i % 100 == 0) ? 16'h0001 : 16'hFFFF;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("rnd_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with a valid/ready handshake on both sides. Operands enter once per cycle. Each pipeline stage resolves a fixed number of 4-bit groups and forwards the group carry to the next stage. It replaces single-cycle 4-bit CLA usage wherever wide operands (16–64 bit) must close timing in the datapath.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4*GPS (elaboration error otherwise).
- GPS, 1: 4-bit groups resolved per pipeline stage; STAGES = WIDTH/(4*GPS).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1, cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1 (in sub mode, 1 means no borrow).
- ovf  out  1  signed two's-complement overflow (see Configuration).

## Operation
- Transfer on input when in_valid && in_ready. Transfer on output when out_valid && out_ready.
- Stage k (0..STAGES−1) holds:
  - a valid bit;
  - the unresolved operand slices (with B already inverted if sub);
  - sum bits resolved so far;
  - the carry into its group range;
  - the sign bits needed for ovf.
- Stage 0 captures the operands and the effective carry-in (sub ? 1 : cin). The carry-in is applied inside stage 0's group logic; the registered value is stage 0's result.
- Within a stage, GPS groups chain their lookahead carries combinationally:
  - group carry = G | (P & c_in);
  - p = a^b, g = a&b per bit.
- Advance rule: stage k loads from k−1 when !v[k] || (stage k advances). The last stage advances when out_ready. in_ready = stage 0 empty or advancing. Bubbles collapse, and full throughput is 1 beat/cycle.
- Stalled stages hold all contents unchanged. sum, cout and ovf are stable while out_valid && !out_ready.
- A simultaneous input and output transfer with a full pipe is legal and loses no beats.
- Results leave in acceptance order; no reordering.

## Timing
- Latency: exactly STAGES cycles from input transfer to out_valid, absent stalls. WIDTH=16, GPS=1 gives 4 cycles.
- All outputs are registered except in_ready, which is combinational from out_ready and the valid bits.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0. All stage valid bits are cleared and in_ready=1 after reset deasserts.
- Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- out_valid never depends combinationally on in_valid.

## Configuration
- Macro: PIPELINED_CLA_OVF_EN.
- Defined: ovf = carry into MSB XOR carry out of MSB, registered with sum and aligned to the same beat.
- Undefined: ovf is tied to 0 and the sign/carry tracking registers are not built. The port remains present.

## Structure
- Package cla_pkg holds:
  - localparam CLA_GRP_W = 4;
  - typedef for the per-group {P,G} pair;
  - function returning STAGES from WIDTH and GPS.
- Sub-module cla_group4 is purely combinational. It has 4-bit a/b, ci, 4-bit s, group P/G and co; GPS instances form each stage.
- The pipeline registers and handshake live in pipelined_cla_adder.

## Test plan
- WIDTH=16, GPS=1, add: a=16'hFFFF, b=16'h0001, cin=0 → after 4 cycles sum=16'h0000, cout=1, ovf=0.
- Sub: a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, ovf=1 (macro on) / 0 (macro off).
- Back-to-back stream of 32 random beats with out_ready=1 → one result per cycle. Every result equals the reference model, and order is preserved.
- Backpressure: hold out_ready=0 for 6 cycles with in_valid=1 → in_ready drops after 4 accepted beats. sum stays stable. After release, all 4 beats drain in order with no loss or duplication.
- Assert rst for 1 cycle while 3 beats are in flight → out_valid=0 and sum=0 immediately. No stale result appears afterwards. The first post-reset beat appears after 4 cycles.
- WIDTH=32, GPS=2: a=32'h7FFFFFFF, b=32'h00000001, cin=1 → after 4 cycles sum=32'h80000001, cout=0, ovf=1.
